// File: rtl/seq_adder_nb.sv
// ---------------------------------------------------------------------------
// seq_adder_nb
//   Multi-cycle adder/subtractor. One CHUNK-bit adder is reused over
//   N = WIDTH/CHUNK cycles, least-significant chunk first. The carry between
//   chunks is held in a register.
//
// Handshake:
//   start is sampled on a rising edge while the block is IDLE or in its
//   single DONE cycle. The operands a, b, sub and cin are captured on that
//   same edge. busy is high for the N cycles that follow. done then pulses
//   for exactly one cycle, and sum/cout/ovf are valid from that cycle onward.
//   A start seen during busy is dropped and is not queued. busy and done are
//   never high together.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        operation request
//   sub          0 = add, 1 = subtract (a - b)
//   cin          carry-in for add; ignored when sub = 1
//   a, b         WIDTH-bit operands
//   busy         chunks being processed
//   done         one-cycle pulse, result registers just updated
//   sum          WIDTH-bit result (mod 2^WIDTH)
//   cout         carry out of the MSB (subtract: 1 = no borrow)
//   ovf          two's-complement overflow
//   dbg_state_o  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module seq_adder_nb #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state_o
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    // Datapath for the chunk currently sitting in the low bits of a_q/b_q.
    logic [CHUNK:0]     chunk_res;
    logic [WIDTH-1:0]   res_shift;
    logic               msb_cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        // The operands are shifted right after each chunk, so the active
        // chunk is always at bit 0.
        chunk_res = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};

        // The new chunk enters at the top of the result register, and
        // everything already there moves down. After N chunks, chunk 0
        // has reached bit 0.
        res_shift = WIDTH'({chunk_res[CHUNK-1:0], res_q} >> CHUNK);

        // On the last chunk, bit CHUNK-1 is the operand MSB. The carry into
        // that bit is recovered as A ^ B ^ S at that position.
        msb_cin   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_res[CHUNK-1];

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtract is a + ~b + 1, so it uses the same adder.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_res[CHUNK];
                res_d   = res_shift;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_shift;
                    cout_d  = chunk_res[CHUNK];
                    ovf_d   = msb_cin ^ chunk_res[CHUNK];
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_adder_nb.sv
// ---------------------------------------------------------------------------
// tb_seq_adder_nb
//   Bench for seq_adder_nb in three configurations: 16/4, 8/8 and 8/1.
//   Expected results come from plain integer arithmetic on a and b.
// ---------------------------------------------------------------------------
module tb_seq_adder_nb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic        sub = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;

    logic        busy0, done0, cout0, ovf0;
    logic        busy1, done1, cout1, ovf1;
    logic        busy2, done2, cout2, ovf2;
    logic [15:0] sum0;
    logic [7:0]  sum1, sum2;
    logic [1:0]  dbg0, dbg1, dbg2;

    seq_adder_nb #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
        .clk(clk), .rst(rst), .start(start0), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy0), .done(done0), .sum(sum0),
        .cout(cout0), .ovf(ovf0), .dbg_state_o(dbg0)
    );

    seq_adder_nb #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .cin(cin),
        .a(a[7:0]), .b(b[7:0]), .busy(busy1), .done(done1), .sum(sum1),
        .cout(cout1), .ovf(ovf1), .dbg_state_o(dbg1)
    );

    seq_adder_nb #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub), .cin(cin),
        .a(a[7:0]), .b(b[7:0]), .busy(busy2), .done(done2), .sum(sum2),
        .cout(cout2), .ovf(ovf2), .dbg_state_o(dbg2)
    );

    // ---------------- selected-instance view ----------------
    int          sel = 0;
    logic        cur_busy, cur_done, cur_cout, cur_ovf;
    logic [15:0] cur_sum;

    always_comb begin
        cur_busy = busy0;
        cur_done = done0;
        cur_cout = cout0;
        cur_ovf  = ovf0;
        cur_sum  = sum0;
        if (sel == 1) begin
            cur_busy = busy1; cur_done = done1; cur_cout = cout1;
            cur_ovf  = ovf1;  cur_sum  = {8'h00, sum1};
        end else if (sel == 2) begin
            cur_busy = busy2; cur_done = done2; cur_cout = cout2;
            cur_ovf  = ovf2;  cur_sum  = {8'h00, sum2};
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integer add/subtract, with signed overflow taken from the
    // range of the true signed result.
    task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv,
                         input logic s, input logic c,
                         output logic [15:0] es, output logic ec, output logic eo);
        longint m, ua, ub, ci, tot, half, sa, sb, st;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(av) & m;
        ub   = longint'(bv) & m;
        ci   = s ? 1 : (c ? 1 : 0);
        // Unsigned view: a - b = a + (2^w - 1 - b) + 1.
        tot  = ua + (s ? (m - ub) : ub) + ci;
        es   = 16'(tot & m);
        ec   = ((tot >> w) & 1) != 0;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        st   = s ? (sa - sb) : (sa + sb + ci);
        eo   = (st >= half) || (st < -half);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_start(input logic v);
        start0 = (sel == 0) ? v : 1'b0;
        start1 = (sel == 1) ? v : 1'b0;
        start2 = (sel == 2) ? v : 1'b0;
    endtask

    // Returns one negedge after the accepting edge.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                         input logic s, input logic c);
        @(negedge clk);
        a = av; b = bv; sub = s; cin = c;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int lat, output int bcnt, output int both);
        lat = 0; bcnt = 0; both = 0;
        while (cur_done !== 1'b1 && lat < 40) begin
            if (cur_busy === 1'b1) bcnt++;
            if (cur_busy === 1'b1 && cur_done === 1'b1) both++;
            @(negedge clk);
            lat++;
        end
        if (cur_busy === 1'b1 && cur_done === 1'b1) both++;
    endtask

    task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic s, input logic c, input int exp_lat, input bit full);
        int lat, bcnt, both, w;
        logic [15:0] es;
        logic ec, eo;
        w = (sel == 0) ? 16 : 8;
        model(w, av, bv, s, c, es, ec, eo);
        issue(av, bv, s, c);
        wait_done(lat, bcnt, both);
        chk({tag, " sum"},  32'(cur_sum),  32'(es));
        chk({tag, " cout"}, 32'(cur_cout), 32'(ec));
        chk({tag, " ovf"},  32'(cur_ovf),  32'(eo));
        chk({tag, " lat"},  32'(lat),      32'(exp_lat));
        if (full) begin
            chk({tag, " busy_cycles"}, 32'(bcnt), 32'(exp_lat));
            chk({tag, " busy_done_excl"}, 32'(both), 32'd0);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat, bcnt, both, dcnt, stable_bad;
        logic [15:0] rav, rbv;
        logic rs, rc;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy0", 32'(busy0), 32'd0);
        chk("rst done0", 32'(done0), 32'd0);
        chk("rst sum0",  32'(sum0),  32'd0);
        chk("rst cout0", 32'(cout0), 32'd0);
        chk("rst ovf0",  32'(ovf0),  32'd0);
        chk("rst sum1",  32'(sum1),  32'd0);
        chk("rst sum2",  32'(sum2),  32'd0);
        rst = 1'b0;

        sel = 0;
        // Add, with latency and busy-length checks
        do_op("add1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 4, 1);
        chk("add1234 const", 32'(sum0), 32'h5555);
        do_op("carry_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4, 1);
        chk("carry_ffff const", 32'({cout0, sum0}), 32'h1_0000);
        do_op("ovf_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 4, 1);
        chk("ovf_7fff const", 32'({ovf0, cout0, sum0}), 32'h2_8000);
        do_op("cin_only", 16'h0000, 16'h0000, 1'b0, 1'b1, 4, 1);
        chk("cin_only const", 32'(sum0), 32'h0001);
        // Subtract, with cin=1 driven to show it is ignored
        do_op("sub5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, 4, 1);
        chk("sub5_7 const", 32'({ovf0, cout0, sum0}), 32'h0_FFFE);
        do_op("sub8000_1", 16'h8000, 16'h0001, 1'b1, 1'b1, 4, 1);
        chk("sub8000_1 const", 32'({ovf0, cout0, sum0}), 32'h3_7FFF);

        // A start two cycles into RUN is ignored
        issue(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(lat, bcnt, both);
        chk("ignore_start sum", 32'(sum0), 32'h3333);
        chk("ignore_start lat", 32'(lat), 32'd2);
        @(negedge clk);
        chk("ignore_start no_queue busy", 32'(busy0), 32'd0);
        chk("ignore_start no_queue done", 32'(done0), 32'd0);

        // Back-to-back: start held during the DONE cycle
        issue(16'h0100, 16'h0200, 1'b0, 1'b0);
        wait_done(lat, bcnt, both);
        chk("b2b first sum", 32'(sum0), 32'h0300);
        a = 16'h1000; b = 16'h0001; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        lat = 0; stable_bad = 0;
        while (done0 !== 1'b1 && lat < 40) begin
            if (sum0 !== 16'h0300) stable_bad++;
            @(negedge clk);
            lat++;
        end
        chk("b2b sum stable", 32'(stable_bad), 32'd0);
        chk("b2b lat", 32'(lat), 32'd4);
        chk("b2b second sum", 32'(sum0), 32'h1001);

        // Asynchronous reset mid-RUN
        issue(16'hF0F0, 16'h0F0F, 1'b0, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst busy", 32'(busy0), 32'd0);
        chk("midrst done", 32'(done0), 32'd0);
        chk("midrst sum",  32'(sum0),  32'd0);
        chk("midrst cout", 32'(cout0), 32'd0);
        chk("midrst ovf",  32'(ovf0),  32'd0);
        chk("midrst state", 32'(dbg0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0 === 1'b1) dcnt++;
        end
        chk("midrst no_done", 32'(dcnt), 32'd0);
        do_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 4, 1);
        chk("post_rst const", 32'(sum0), 32'h0002);

        // Random sweep over the three configurations
        for (int cfg = 0; cfg < 3; cfg++) begin
            sel = cfg;
            for (int i = 0; i < 200; i++) begin
                rav = 16'($urandom);
                rbv = 16'($urandom);
                rs  = 1'($urandom_range(0, 1));
                rc  = 1'($urandom_range(0, 1));
                do_op($sformatf("rnd c%0d i%0d", cfg, i), rav, rbv, rs, rc,
                      (cfg == 0) ? 4 : ((cfg == 1) ? 1 : 8), (i < 4));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_adder_nb.md
# seq_adder_nb

Parametrised multi-cycle adder/subtractor, the successor to the fixed 4-bit ripple-carry adder in the lab datapath. It adds or subtracts two WIDTH-bit operands by reusing one CHUNK-bit adder over WIDTH/CHUNK clock cycles, least-significant chunk first. The carry is held in a register between chunks. A start/busy/done handshake lets a controller FSM issue operations and collect sum, carry-out and signed overflow.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK is the number of chunks.
- clk  input  1  clock; all registers update on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  operation request; sampled on the rising edge.
- sub  input  1  mode: 0 = add, 1 = subtract; sampled with start.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while chunks are being processed.
- done  output  1  one-cycle pulse; result registers were updated on the preceding edge.
- sum  output  WIDTH  result (mod 2^WIDTH).
- cout  output  1  carry out of the MSB; in subtract mode 1 means no borrow.
- ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - start=1 → RUN.
  - On the same edge: latch A = a, B = sub ? ~b : b, carry = sub ? 1 : cin, chunk counter = 0.
- RUN, one edge per chunk k = 0..N-1:
  - {c, s} = A[k] + B[k] + carry, where A[k] and B[k] are the CHUNK-bit slices.
  - Store s into the internal result slice k; carry ← c; counter++.
  - On chunk N-1, also capture the carry into the MSB (bit WIDTH-2 → WIDTH-1), load sum/cout/ovf from the internal result, and go to DONE.
- DONE: lasts one cycle, done=1.
  - start=1 → accepted as in IDLE (back-to-back), next state RUN.
  - Otherwise → IDLE.
- start while in RUN is ignored, with no queuing. Changes on a, b, sub, cin during RUN have no effect.
- sum, cout, ovf hold the last completed result until the next DONE entry. They are never updated chunk by chunk.
- Reset at any time, including mid-RUN:
  - State goes to IDLE; busy, done, sum, cout, ovf go to 0.
  - The internal operand, carry and counter registers clear.
  - No done pulse is produced for the aborted operation.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0.

## Timing
- Edge t accepts start. busy=1 during the N cycles following edge t.
- The last chunk is processed on edge t+N. From that edge, done=1 for one cycle, busy=0, and sum/cout/ovf are valid.
- Latency from the start-accept edge to valid result: N edges (4 for the defaults; 1 when CHUNK=WIDTH).
- Throughput with back-to-back starts: one result per N+1 cycles.
- busy and done are never high in the same cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Add: a=0x1234, b=0x4321, cin=0, sub=0 → sum=0x5555, cout=0, ovf=0. done pulses exactly 4 edges after start, and busy is high for exactly 4 cycles.
- Carry/overflow: a=0xFFFF, b=0x0001 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Then a=0x0000, b=0x0000, cin=1 → sum=0x0001.
- Subtract, with cin=1 driven to prove it is ignored:
  - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Handshake:
  - A start pulse two cycles into RUN, with changed a/b, → ignored; the first result is unchanged.
  - start held high in the DONE cycle → the new operation begins. Its result appears N edges later, and the previous sum stays stable until then.
- Reset: assert rst asynchronously mid-cycle two edges into RUN → busy, done, sum, cout, ovf drop to 0 immediately, and no done follows. After release, a new add of 0x0001+0x0001 → sum=0x0002.
- Parameter sweep:
  - WIDTH=8, CHUNK=8 → latency 1.
  - WIDTH=8, CHUNK=1 → latency 8.
  - Each configuration checked against 200 random a/b/sub/cin vectors, compared to a reference a±b model including cout and ovf.
